enc_quad_decoder: RTL and testbench



---
 rtl/enc_pkg.sv | 32 +++
 rtl/enc_quad_channel.sv | 172 +++++++++++++++++
 rtl/enc_quad_decoder.sv | 52 +++++
 tb/tb_enc_quad_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared encodings for the quadrature decoder: decode modes, Gray states of
// {A,B}, direction polarity and a Gray-to-phase helper.
package enc_pkg;

    typedef enum logic [1:0] {
        ENC_MODE_1X = 2'b00,
        ENC_MODE_2X = 2'b01,
        ENC_MODE_4X = 2'b10
    } enc_mode_e;

    localparam logic [1:0] ENC_AB_00 = 2'b00;
    localparam logic [1:0] ENC_AB_10 = 2'b10;
    localparam logic [1:0] ENC_AB_11 = 2'b11;
    localparam logic [1:0] ENC_AB_01 = 2'b01;

    localparam logic ENC_DIR_FWD = 1'b1;
    localparam logic ENC_DIR_REV = 1'b0;

    // Phase index along the forward sequence 00->10->11->01, so a forward
    // step is always a +1 (mod 4) difference in phase.
    function automatic logic [1:0] enc_phase(input logic [1:0] ab);
        logic [1:0] ph;
        case (ab)
            ENC_AB_00: ph = 2'd0;
            ENC_AB_10: ph = 2'd1;
            ENC_AB_11: ph = 2'd2;
            default:   ph = 2'd3;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/enc_quad_channel.sv
// One encoder channel: 2-FF synchronisers, per-input glitch filters, the
// quadrature decoder and the position / revolution counters.
module enc_quad_channel
    import enc_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int CIR_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_z,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] cpr,
    input  logic             zero_en,
    input  logic             clr,
    output logic [CNT_W-1:0] pos,
    output logic [CIR_W-1:0] cir,
    output logic             dir,
    output logic             step,
    output logic             idx,
    output logic             err
);

    localparam int             FCW       = $clog2(FILT_LEN + 1);
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT_LEN - 1);

    // Bit order in the sync/filter vectors: {Z, A, B}.
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_filt;
    logic [FCW-1:0]   r_fcnt [3];
    logic [1:0]       r_prev_ab;
    logic             r_prev_z;
    logic [CNT_W-1:0] r_pos;
    logic [CIR_W-1:0] r_cir;
    logic             r_dir;
    logic             r_step;
    logic             r_idx;
    logic             r_err;

    logic [1:0]       w_ab;
    logic [1:0]       w_chg;
    logic [1:0]       w_delta;
    logic             w_valid;
    logic             w_illegal;
    logic             w_fwd;
    logic             w_qual;
    logic             w_z_rise;
    logic             w_zero;
    logic [CNT_W-1:0] w_cpr_last;
    logic [CNT_W-1:0] w_pos_nxt;
    logic [CIR_W-1:0] w_cir_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {enc_z, enc_a, enc_b};
            r_sync2 <= r_sync1;
        end
    end

    // A filtered level flips only after FILT_LEN consecutive disagreeing
    // samples; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= '0;
            for (int i = 0; i < 3; i++) r_fcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_filt[i]) begin
                    if (r_fcnt[i] == FCNT_LAST) begin
                        r_filt[i] <= r_sync2[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + 1'b1;
                    end
                end else begin
                    r_fcnt[i] <= '0;
                end
            end
        end
    end

    assign w_ab       = r_filt[1:0];
    assign w_chg      = w_ab ^ r_prev_ab;
    assign w_valid    = ^w_chg;
    assign w_illegal  = &w_chg;
    assign w_delta    = enc_phase(w_ab) - enc_phase(r_prev_ab);
    assign w_fwd      = (w_delta == 2'd1);
    assign w_z_rise   = r_filt[2] & ~r_prev_z;
    assign w_zero     = w_z_rise & zero_en;
    assign w_cpr_last = cpr - 1'b1;

    always_comb begin
        w_qual = 1'b0;
        case (mode)
            ENC_MODE_1X: w_qual = w_valid & w_chg[1] & ~w_ab[0];
            ENC_MODE_2X: w_qual = w_valid & w_chg[1];
            ENC_MODE_4X: w_qual = w_valid;
            default:     w_qual = w_valid;
        endcase
    end

    // A position at or beyond cpr-1 (cpr may have been lowered) wraps to 0
    // going forward; going backward it simply decrements.
    always_comb begin
        w_pos_nxt = r_pos;
        w_cir_nxt = r_cir;
        if (w_qual) begin
            if (w_fwd) begin
                if (r_pos >= w_cpr_last) begin
                    w_pos_nxt = '0;
                    w_cir_nxt = r_cir + CIR_W'(1);
                end else begin
                    w_pos_nxt = r_pos + CNT_W'(1);
                end
            end else begin
                if (r_pos == '0) begin
                    w_pos_nxt = w_cpr_last;
                    w_cir_nxt = r_cir - CIR_W'(1);
                end else begin
                    w_pos_nxt = r_pos - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_ab <= ENC_AB_00;
            r_prev_z  <= 1'b0;
            r_pos     <= '0;
            r_cir     <= '0;
            r_dir     <= 1'b0;
            r_step    <= 1'b0;
            r_idx     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_prev_ab <= w_ab;
            r_prev_z  <= r_filt[2];
            r_step    <= w_qual;
            r_idx     <= w_z_rise;
            if (w_qual) r_dir <= w_fwd ? ENC_DIR_FWD : ENC_DIR_REV;
            if (clr) begin
                r_pos <= '0;
                r_cir <= '0;
                r_err <= 1'b0;
            end else begin
                if (w_illegal) r_err <= 1'b1;
                if (w_zero) begin
                    r_pos <= '0;
                end else begin
                    r_pos <= w_pos_nxt;
                    r_cir <= w_cir_nxt;
                end
            end
        end
    end

    assign pos  = r_pos;
    assign cir  = r_cir;
    assign dir  = r_dir;
    assign step = r_step;
    assign idx  = r_idx;
    assign err  = r_err;

endmodule

// File: rtl/enc_quad_decoder.sv
// Multi-channel quadrature decoder: one enc_quad_channel per encoder, with the
// per-channel results packed into flat output buses.
module enc_quad_decoder
    import enc_pkg::*;
#(
    parameter int CH_NUM   = 2,
    parameter int CNT_W    = 16,
    parameter int CIR_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH_NUM-1:0]       enc_a,
    input  logic [CH_NUM-1:0]       enc_b,
    input  logic [CH_NUM-1:0]       enc_z,
    input  logic [1:0]              mode,
    input  logic [CNT_W-1:0]        cpr,
    input  logic                    zero_en,
    input  logic                    clr,
    output logic [CH_NUM*CNT_W-1:0] pos,
    output logic [CH_NUM*CIR_W-1:0] cir,
    output logic [CH_NUM-1:0]       dir,
    output logic [CH_NUM-1:0]       step,
    output logic [CH_NUM-1:0]       idx,
    output logic [CH_NUM-1:0]       err
);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        enc_quad_channel #(
            .CNT_W    (CNT_W),
            .CIR_W    (CIR_W),
            .FILT_LEN (FILT_LEN)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .enc_a   (enc_a[g]),
            .enc_b   (enc_b[g]),
            .enc_z   (enc_z[g]),
            .mode    (mode),
            .cpr     (cpr),
            .zero_en (zero_en),
            .clr     (clr),
            .pos     (pos[g*CNT_W +: CNT_W]),
            .cir     (cir[g*CIR_W +: CIR_W]),
            .dir     (dir[g]),
            .step    (step[g]),
            .idx     (idx[g]),
            .err     (err[g])
        );
    end

endmodule

// File: tb/tb_enc_quad_decoder.sv
// Bench for enc_quad_decoder: directed scenarios plus randomized moves checked
// against a behavioural model of pin-level encoder motion.
module tb_enc_quad_decoder;
    import enc_pkg::*;

    localparam int CH  = 2;
    localparam int CW  = 16;
    localparam int RW  = 16;
    localparam int FL  = 4;
    localparam int LAT = FL + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     enc_a, enc_b, enc_z;
    logic [1:0]        mode;
    logic [CW-1:0]     cpr;
    logic              zero_en, clr;
    logic [CH*CW-1:0]  pos;
    logic [CH*RW-1:0]  cir;
    logic [CH-1:0]     dir, step, idx, err;

    enc_quad_decoder #(.CH_NUM(CH), .CNT_W(CW), .CIR_W(RW), .FILT_LEN(FL)) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .mode(mode), .cpr(cpr), .zero_en(zero_en), .clr(clr),
        .pos(pos), .cir(cir), .dir(dir), .step(step), .idx(idx), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase along the forward sequence, counters, flags.
    int          m_gi    [CH];
    int          m_pos   [CH];
    logic [RW-1:0] m_cir [CH];
    logic        m_dir   [CH];
    logic        m_err   [CH];
    logic        m_z     [CH];
    int          m_steps [CH] = '{default: 0};
    int          m_idx   [CH] = '{default: 0};
    int          d_steps [CH] = '{default: 0};
    int          d_idx   [CH] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (step[i]) d_steps[i]++;
            if (idx[i])  d_idx[i]++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] ab_of(input int gi);
        case (gi)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic drive_pins();
        logic [1:0] ab;
        for (int i = 0; i < CH; i++) begin
            ab       = ab_of(m_gi[i]);
            enc_a[i] = ab[1];
            enc_b[i] = ab[0];
            enc_z[i] = m_z[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_gi[i]  = 0;
            m_pos[i] = 0;
            m_cir[i] = '0;
            m_dir[i] = 1'b0;
            m_err[i] = 1'b0;
            m_z[i]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive_pins();
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_pos[i] = 0;
            m_cir[i] = '0;
            m_err[i] = 1'b0;
        end
    endtask

    // kind: 0 forward step, 1 reverse step, 2 illegal double change, 3 toggle Z
    task automatic move(input int ch, input int kind);
        logic [1:0] o, n;
        bit counted, a_chg, fwd;
        if (kind == 3) begin
            m_z[ch] = ~m_z[ch];
            if (m_z[ch]) begin
                m_idx[ch]++;
                if (zero_en) m_pos[ch] = 0;
            end
        end else begin
            o = ab_of(m_gi[ch]);
            m_gi[ch] = (m_gi[ch] + (kind == 0 ? 1 : kind == 1 ? 3 : 2)) % 4;
            n = ab_of(m_gi[ch]);
            if (kind == 2) begin
                m_err[ch] = 1'b1;
            end else begin
                fwd   = (kind == 0);
                a_chg = (o[1] != n[1]);
                if (mode[1])      counted = 1'b1;
                else if (mode[0]) counted = a_chg;
                else              counted = a_chg && !n[0];
                if (counted) begin
                    m_steps[ch]++;
                    m_dir[ch] = fwd;
                    if (fwd) begin
                        m_pos[ch] = m_pos[ch] + 1;
                        if (m_pos[ch] >= int'(cpr)) begin
                            m_pos[ch] = 0;
                            m_cir[ch] = m_cir[ch] + 1'b1;
                        end
                    end else if (m_pos[ch] == 0) begin
                        m_pos[ch] = int'(cpr) - 1;
                        m_cir[ch] = m_cir[ch] - 1'b1;
                    end else begin
                        m_pos[ch] = m_pos[ch] - 1;
                    end
                end
            end
        end
        drive_pins();
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < CH; i++) begin
            check_val($sformatf("%s pos%0d", tag, i),   32'(pos[i*CW +: CW]), 32'(m_pos[i]));
            check_val($sformatf("%s cir%0d", tag, i),   32'(cir[i*RW +: RW]), 32'(m_cir[i]));
            check_val($sformatf("%s dir%0d", tag, i),   32'(dir[i]),          32'(m_dir[i]));
            check_val($sformatf("%s err%0d", tag, i),   32'(err[i]),          32'(m_err[i]));
            check_val($sformatf("%s steps%0d", tag, i), 32'(d_steps[i]),      32'(m_steps[i]));
            check_val($sformatf("%s idx%0d", tag, i),   32'(d_idx[i]),        32'(m_idx[i]));
        end
    endtask

    initial begin
        int r, kind;
        rst = 1'b1; clr = 1'b0; zero_en = 1'b0;
        mode = ENC_MODE_4X; cpr = 16'd4000;
        model_reset();
        drive_pins();
        tick(3);
        check_val("reset pos", 32'(pos), 32'h0);
        check_val("reset cir", 32'(cir), 32'h0);
        check_val("reset flags", 32'({dir, step, idx, err}), 32'h0);
        rst = 1'b0;
        tick(1);

        // Eight forward steps on ch0 only.
        repeat (8) begin move(0, 0); tick(10); end
        check_val("fwd8 pos0", 32'(pos[CW-1:0]), 32'd8);
        check_val("fwd8 dir0", 32'(dir[0]), 32'd1);
        check_val("fwd8 steps0", 32'(d_steps[0]), 32'(m_steps[0]));
        check_val("fwd8 pos1", 32'(pos[2*CW-1:CW]), 32'd0);
        check_val("fwd8 steps1", 32'(d_steps[1]), 32'd0);
        check_all("fwd8");

        // Single reverse step from reset underflows to cpr-1.
        do_reset();
        move(0, 1); tick(10);
        check_val("rev1 pos0", 32'(pos[CW-1:0]), 32'd3999);
        check_val("rev1 cir0", 32'(cir[RW-1:0]), 32'hffff);
        check_val("rev1 dir0", 32'(dir[0]), 32'd0);

        // Revolution wrap with cpr=8.
        do_reset();
        cpr = 16'd8;
        repeat (8) begin move(0, 0); tick(10); end
        check_val("wrap pos0", 32'(pos[CW-1:0]), 32'd0);
        check_val("wrap cir0", 32'(cir[RW-1:0]), 32'd1);
        move(0, 1); tick(10);
        check_val("unwrap pos0", 32'(pos[CW-1:0]), 32'd7);
        check_val("unwrap cir0", 32'(cir[RW-1:0]), 32'd0);

        // Short glitch is rejected; a real edge lands FILT_LEN+3 edges later.
        do_reset();
        cpr = 16'd4000;
        enc_a[0] = 1'b1; tick(FL - 1); enc_a[0] = 1'b0; tick(12);
        check_val("glitch pos0", 32'(pos[CW-1:0]), 32'd0);
        check_val("glitch steps0", 32'(d_steps[0]), 32'(m_steps[0]));
        move(0, 0);
        tick(LAT - 1);
        check_val("lat early pos0", 32'(pos[CW-1:0]), 32'd0);
        check_val("lat early step0", 32'(step[0]), 32'd0);
        tick(1);
        check_val("lat pos0", 32'(pos[CW-1:0]), 32'd1);
        check_val("lat step0", 32'(step[0]), 32'd1);
        tick(1);
        check_val("lat step0 low", 32'(step[0]), 32'd0);

        // Illegal transition sets sticky err without counting; clr clears.
        do_reset();
        move(0, 0); tick(10); move(0, 0); tick(10);
        move(0, 2); tick(10);
        check_val("illegal err0", 32'(err[0]), 32'd1);
        check_val("illegal pos0", 32'(pos[CW-1:0]), 32'd2);
        check_all("illegal");
        move(0, 0); tick(10);
        check_val("post illegal pos0", 32'(pos[CW-1:0]), 32'd3);
        check_val("post illegal err0", 32'(err[0]), 32'd1);
        pulse_clr(); tick(1);
        check_val("clr err0", 32'(err[0]), 32'd0);
        check_val("clr pos0", 32'(pos[CW-1:0]), 32'd0);
        check_val("clr cir0", 32'(cir[RW-1:0]), 32'd0);

        // 1x decoding and Z homing.
        do_reset();
        mode = ENC_MODE_1X;
        repeat (4) begin move(0, 0); tick(10); end
        check_val("1x pos0", 32'(pos[CW-1:0]), 32'd1);
        zero_en = 1'b1;
        move(0, 3); tick(10);
        check_val("zero pos0", 32'(pos[CW-1:0]), 32'd0);
        check_val("zero cir0", 32'(cir[RW-1:0]), 32'd0);
        check_val("zero idx0", 32'(d_idx[0]), 32'(m_idx[0]));
        move(0, 3); tick(10);
        zero_en = 1'b0;
        repeat (4) begin move(0, 0); tick(10); end
        move(0, 3); tick(10);
        check_val("nozero pos0", 32'(pos[CW-1:0]), 32'd1);
        check_all("nozero");

        // Randomized moves on both channels with random mode/cpr/zero_en.
        do_reset();
        mode = ENC_MODE_4X; cpr = 16'd4000;
        for (int it = 0; it < 300; it++) begin
            if (it == 150) do_reset();
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) cpr = ($urandom_range(0, 3) == 0) ? 16'd4000 : 16'($urandom_range(2, 12));
            zero_en = 1'($urandom_range(0, 1));
            for (int ch = 0; ch < CH; ch++) begin
                r = $urandom_range(0, 15);
                kind = (r == 0) ? 2 : (r == 1) ? 3 : (r < 9) ? 0 : 1;
                move(ch, kind);
            end
            tick(LAT + 1);
            if ($urandom_range(0, 24) == 0) begin pulse_clr(); tick(1); end
            check_all($sformatf("rand%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
